// File: rtl/sram_like_arbiter_if.sv
// One sram-like port: request fields flow master->slave, handshakes and read data flow back.
interface sram_like_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Round-robin arbiter: inst and data sram-like ports share one downstream port,
// with a single outstanding transaction.
module sram_like_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    sram_like_arbiter_if.slave  inst,
    sram_like_arbiter_if.slave  data,
    sram_like_arbiter_if.master bus
);
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    typedef struct packed {
        logic              req;
        logic              wr;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    state_t                state, state_nxt;
    logic                  grant, grant_nxt;
    logic                  last, last_nxt;
    req_t [NUM_PORTS-1:0]  port_req;
    rsp_t [NUM_PORTS-1:0]  port_rsp;
    req_t                  sel;
    req_t                  bus_out;
    rsp_t                  gnt_rsp;

    assign port_req[0] = {inst.req, inst.wr, inst.size, inst.addr, inst.wdata};
    assign port_req[1] = {data.req, data.wr, data.size, data.addr, data.wdata};
    assign sel         = port_req[grant];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (port_req[0].req || port_req[1].req) begin
                    state_nxt = ADDR;
                    // On a tie the port served least recently wins.
                    if (port_req[0].req && port_req[1].req)
                        grant_nxt = ~last;
                    else
                        grant_nxt = port_req[1].req;
                end
            end
            ADDR: begin
                if (!sel.req) begin
                    state_nxt = IDLE;
                end else if (bus.addr_ok) begin
                    last_nxt  = grant;
                    state_nxt = bus.data_ok ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bus.data_ok)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus_out = '0;
        gnt_rsp = '0;
        case (state)
            ADDR: begin
                bus_out         = sel;
                gnt_rsp.addr_ok = bus.addr_ok;
                // A zero-latency slave may finish the data phase in the same cycle.
                gnt_rsp.data_ok = bus.addr_ok & bus.data_ok;
            end
            DATA: gnt_rsp.data_ok = bus.data_ok;
            default: ;
        endcase
        gnt_rsp.rdata = gnt_rsp.data_ok ? bus.rdata : '0;
        for (int p = 0; p < NUM_PORTS; p++)
            port_rsp[p] = (grant == 1'(p)) ? gnt_rsp : '0;
    end

    assign bus.req       = bus_out.req;
    assign bus.wr        = bus_out.wr;
    assign bus.size      = bus_out.size;
    assign bus.addr      = bus_out.addr;
    assign bus.wdata     = bus_out.wdata;

    assign inst.addr_ok  = port_rsp[0].addr_ok;
    assign inst.data_ok  = port_rsp[0].data_ok;
    assign inst.rdata    = port_rsp[0].rdata;
    assign data.addr_ok  = port_rsp[1].addr_ok;
    assign data.data_ok  = port_rsp[1].data_ok;
    assign data.rdata    = port_rsp[1].rdata;
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Random requesters and a random-latency slave; a transaction-level model predicts every output.
module tb_sram_like_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CYCLES = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_like_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) inst_if ();
    sram_like_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) data_if ();
    sram_like_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    sram_like_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk  (clk),
        .rst  (rst),
        .inst (inst_if),
        .data (data_if),
        .bus  (bus_if)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // requester state (0=inst, 1=data)
    logic          p_req[2], p_wait[2], p_wr[2];
    logic [1:0]    p_size[2];
    logic [AW-1:0] p_addr[2];
    logic [DW-1:0] p_wdata[2];

    // reference model: current owner (-1 = bus free), address accepted, last served
    int   own, last;
    logic acc, s_busy;

    logic          o_aok[2], o_dok[2];
    logic          exp_breq;
    logic [66:0]   exp_bf;
    logic          exp_aok[2], exp_dok[2];
    logic [DW-1:0] exp_rd[2];

    task automatic drive_ports();
        inst_if.req = p_req[0]; inst_if.wr = p_wr[0]; inst_if.size = p_size[0];
        inst_if.addr = p_addr[0]; inst_if.wdata = p_wdata[0];
        data_if.req = p_req[1]; data_if.wr = p_wr[1]; data_if.size = p_size[1];
        data_if.addr = p_addr[1]; data_if.wdata = p_wdata[1];
    endtask

    initial begin
        own = -1; last = 0; acc = 1'b0; s_busy = 1'b0;
        for (int p = 0; p < 2; p++) begin
            p_req[p] = 1'b0; p_wait[p] = 1'b0; p_wr[p] = 1'b0;
            p_size[p] = '0; p_addr[p] = '0; p_wdata[p] = '0;
        end
        drive_ports();
        bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0; bus_if.rdata = '0;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            rst = (cyc < 2) || ($urandom_range(149) == 0);

            for (int p = 0; p < 2; p++) begin
                if (!p_req[p] && !p_wait[p]) begin
                    if ($urandom_range(1) == 1) begin
                        p_req[p]   = 1'b1;
                        p_wr[p]    = 1'($urandom_range(1));
                        p_size[p]  = 2'($urandom_range(2));
                        p_addr[p]  = $urandom;
                        p_wdata[p] = $urandom;
                    end
                end else if (p_req[p] && $urandom_range(19) == 0) begin
                    p_req[p] = 1'b0;
                end
            end
            drive_ports();

            bus_if.rdata   = $urandom;
            bus_if.addr_ok = 1'b0;
            bus_if.data_ok = s_busy && ($urandom_range(2) == 0);
            #1;
            if (!s_busy && bus_if.req && $urandom_range(1) == 1) begin
                bus_if.addr_ok = 1'b1;
                bus_if.data_ok = ($urandom_range(2) == 0);
            end else if (!s_busy && !bus_if.req && $urandom_range(7) == 0) begin
                bus_if.data_ok = 1'b1;
            end
            #1;

            exp_breq = 1'b0;
            exp_bf   = '0;
            for (int p = 0; p < 2; p++) begin
                exp_aok[p] = 1'b0;
                exp_dok[p] = 1'b0;
            end
            if (own >= 0 && !acc) begin
                exp_breq     = p_req[own];
                exp_bf       = {p_wr[own], p_size[own], p_addr[own], p_wdata[own]};
                exp_aok[own] = bus_if.addr_ok;
                exp_dok[own] = bus_if.addr_ok & bus_if.data_ok;
            end else if (own >= 0) begin
                exp_dok[own] = bus_if.data_ok;
            end
            for (int p = 0; p < 2; p++)
                exp_rd[p] = exp_dok[p] ? bus_if.rdata : '0;

            o_aok[0] = inst_if.addr_ok; o_dok[0] = inst_if.data_ok;
            o_aok[1] = data_if.addr_ok; o_dok[1] = data_if.data_ok;

            chk("bus_req", 128'(bus_if.req), 128'(exp_breq));
            chk("bus_fields", 128'({bus_if.wr, bus_if.size, bus_if.addr, bus_if.wdata}), 128'(exp_bf));
            chk("inst_hs", 128'({o_aok[0], o_dok[0]}), 128'({exp_aok[0], exp_dok[0]}));
            chk("inst_rdata", 128'(inst_if.rdata), 128'(exp_rd[0]));
            chk("data_hs", 128'({o_aok[1], o_dok[1]}), 128'({exp_aok[1], exp_dok[1]}));
            chk("data_rdata", 128'(data_if.rdata), 128'(exp_rd[1]));

            // advance model, requesters and slave to what the coming edge produces
            if (rst) begin
                own = -1; acc = 1'b0; last = 0; s_busy = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    p_req[p] = 1'b0;
                    p_wait[p] = 1'b0;
                end
            end else begin
                if (own < 0) begin
                    if (p_req[0] || p_req[1]) begin
                        own = (p_req[0] && p_req[1]) ? 1 - last : (p_req[1] ? 1 : 0);
                        acc = 1'b0;
                    end
                end else if (!acc) begin
                    if (!p_req[own]) begin
                        own = -1;
                    end else if (bus_if.addr_ok) begin
                        last = own;
                        if (bus_if.data_ok) own = -1;
                        else acc = 1'b1;
                    end
                end else if (bus_if.data_ok) begin
                    own = -1;
                end

                for (int p = 0; p < 2; p++) begin
                    if (p_req[p] && o_aok[p]) begin
                        p_req[p]  = 1'b0;
                        p_wait[p] = !o_dok[p];
                    end else if (p_wait[p] && o_dok[p]) begin
                        p_wait[p] = 1'b0;
                    end
                end

                if (!s_busy) s_busy = bus_if.addr_ok && !bus_if.data_ok;
                else if (bus_if.data_ok) s_busy = 1'b0;
            end
            @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
